// File: rtl/pipe_cla.sv
// pipe_cla: pipelined carry-lookahead adder/subtractor, one K-bit chunk resolved per stage
module pipe_cla #(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout
);
    localparam int S = W / K;

    logic         w_en;
    logic [S:0]   w_v, w_c;
    logic         r_v0, r_c0;
    logic [W-1:0] r_a0, r_b0;

    function automatic logic [K:0] cla(input logic [K-1:0] x, input logic [K-1:0] y, input logic c0);
        logic [K:0]   c;
        logic [K-1:0] g, p;
        logic         t, q;
        g = x & y;
        p = x ^ y;
        c[0] = c0;
        for (int j = 0; j < K; j++) begin
            t = g[j];
            q = p[j];
            for (int m = j - 1; m >= 0; m--) begin
                t = t | (q & g[m]);
                q = q & p[m];
            end
            c[j+1] = t | (q & c0);
        end
        return c;
    endfunction

    assign w_en      = !(out_valid && !out_ready);
    assign in_ready  = w_en;
    assign w_v[0]    = r_v0;
    assign w_c[0]    = r_c0;
    assign out_valid = w_v[S];
    assign cout      = w_c[S];

    // Subtraction folds into addition: B is inverted and the carry-in forced high here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_c0 <= 1'b0;
            r_a0 <= '0;
            r_b0 <= '0;
        end else if (w_en) begin
            r_v0 <= in_valid;
            r_c0 <= sub | cin;
            r_a0 <= a;
            r_b0 <= sub ? ~b : b;
        end
    end

    for (genvar i = 0; i < S; i++) begin : g_st
        logic [W-i*K-1:0]   w_ua, w_ub;
        logic [(i+1)*K-1:0] w_ns;
        logic [K:0]         w_cy;
        logic               r_v, r_c;
        logic [(i+1)*K-1:0] r_s;
        assign w_cy = cla(w_ua[K-1:0], w_ub[K-1:0], w_c[i]);
        if (i == 0) begin : g_first
            assign w_ua = r_a0;
            assign w_ub = r_b0;
            assign w_ns = w_ua[K-1:0] ^ w_ub[K-1:0] ^ w_cy[K-1:0];
        end else begin : g_next
            assign w_ua = g_st[i-1].g_sk.r_a;
            assign w_ub = g_st[i-1].g_sk.r_b;
            assign w_ns = {w_ua[K-1:0] ^ w_ub[K-1:0] ^ w_cy[K-1:0], g_st[i-1].r_s};
        end
        if (i < S - 1) begin : g_sk
            logic [W-(i+1)*K-1:0] r_a, r_b;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_ua[W-i*K-1:K];
                    r_b <= w_ub[W-i*K-1:K];
                end
            end
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_v[i];
                r_c <= w_cy[K];
                r_s <= w_ns;
            end
        end
        assign w_v[i+1] = r_v;
        assign w_c[i+1] = r_c;
    end

    assign sum = g_st[S-1].r_s;
endmodule

// File: tb/tb_pipe_cla.sv
// tb_pipe_cla: directed checks on W=16/K=4 plus randomized checks on K=4, K=16 and K=1 builds
module tb_pipe_cla;
    logic        clk = 1'b0;
    logic        rst;
    logic        vi[3], vcin[3], vsub[3], ordy[3];
    logic [15:0] va[3], vb[3];
    logic        iry[3], ov[3], co[3];
    logic [15:0] s[3];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_cla #(.W(16), .K(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(vi[0]), .in_ready(iry[0]), .a(va[0]), .b(vb[0]),
        .cin(vcin[0]), .sub(vsub[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s[0]), .cout(co[0])
    );
    pipe_cla #(.W(16), .K(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(vi[1]), .in_ready(iry[1]), .a(va[1]), .b(vb[1]),
        .cin(vcin[1]), .sub(vsub[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s[1]), .cout(co[1])
    );
    pipe_cla #(.W(16), .K(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(vi[2]), .in_ready(iry[2]), .a(va[2]), .b(vb[2]),
        .cin(vcin[2]), .sub(vsub[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s[2]), .cout(co[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        vi[0]   = 1'b0;
        ordy[0] = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_chk++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ov[0]); end
        n_chk++; if (s[0] !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h want 0000", s[0]); end
        n_chk++; if (co[0] !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", co[0]); end
        n_chk++; if (iry[0] !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", iry[0]); end
        rst = 1'b0;
    endtask

    task automatic test_ripple();
        idle();
        vi[0] = 1'b1; va[0] = 16'hFFFF; vb[0] = 16'h0001; vcin[0] = 1'b0; vsub[0] = 1'b0;
        tick();
        vi[0] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            n_chk++;
            if (k < 4) begin
                if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL ripple_early k=%0d: got valid %b want 0", k, ov[0]); end
            end else if ({ov[0], co[0], s[0]} !== {1'b1, 1'b1, 16'h0000}) begin
                n_fail++; $display("FAIL ripple: got v=%b c=%b s=%h want v=1 c=1 s=0000", ov[0], co[0], s[0]);
            end
        end
    endtask

    task automatic test_vectors();
        logic [15:0] ta[6], tb_[6], te[6];
        logic [5:0]  tc, ts, tco;
        ta  = '{16'h0005, 16'h1234, 16'h0000, 16'h8000, 16'h00FF, 16'h0F0F};
        tb_ = '{16'h0007, 16'h1234, 16'h0001, 16'h8000, 16'h0001, 16'hF0F0};
        te  = '{16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001, 16'h0100, 16'h0000};
        tc  = 6'b101010;
        ts  = 6'b000111;
        tco = 6'b101010;
        idle();
        for (int c = 0; c < 10; c++) begin
            vi[0] = (c < 6);
            if (c < 6) begin va[0] = ta[c]; vb[0] = tb_[c]; vcin[0] = tc[c]; vsub[0] = ts[c]; end
            tick();
            n_chk++;
            if (c >= 4) begin
                if ({ov[0], co[0], s[0]} !== {1'b1, tco[c-4], te[c-4]}) begin
                    n_fail++; $display("FAIL vector%0d: got v=%b c=%b s=%h want v=1 c=%b s=%h", c-4, ov[0], co[0], s[0], tco[c-4], te[c-4]);
                end
            end else if (ov[0] !== 1'b0) begin
                n_fail++; $display("FAIL vector_latency c=%0d: got valid %b want 0", c, ov[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        idle();
        for (int c = 0; c < 12; c++) begin
            vi[0] = (c < 8); va[0] = 16'(c); vb[0] = 16'h0100; vcin[0] = 1'b1; vsub[0] = 1'b0;
            tick();
            n_chk++;
            if (c >= 4) begin
                if ({ov[0], co[0], s[0]} !== {1'b1, 1'b0, 16'(16'h0101 + (c - 4))}) begin
                    n_fail++; $display("FAIL b2b%0d: got v=%b c=%b s=%h want v=1 c=0 s=%h", c-4, ov[0], co[0], s[0], 16'(16'h0101 + (c - 4)));
                end
            end else if (ov[0] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_latency c=%0d: got valid %b want 0", c, ov[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int ne = 0;
        idle();
        for (int cyc = 0; cyc < 40; cyc++) begin
            vi[0] = (idx < 8); va[0] = 16'(idx + 1); vb[0] = 16'h2000; vcin[0] = 1'b0; vsub[0] = 1'b0;
            ordy[0] = (cyc >= 10);
            #1;
            n_chk++;
            if (iry[0] !== (cyc < 5 || cyc >= 10)) begin
                n_fail++; $display("FAIL bp_ready cyc=%0d: got %b want %b", cyc, iry[0], (cyc < 5 || cyc >= 10));
            end
            if (cyc >= 5 && cyc < 10) begin
                n_chk++;
                if ({ov[0], co[0], s[0]} !== {1'b1, 1'b0, 16'h2001}) begin
                    n_fail++; $display("FAIL bp_hold cyc=%0d: got v=%b c=%b s=%h want v=1 c=0 s=2001", cyc, ov[0], co[0], s[0]);
                end
            end
            if (ov[0] && ordy[0]) begin
                n_chk++;
                if ({co[0], s[0]} !== {1'b0, 16'(16'h2001 + ne)}) begin
                    n_fail++; $display("FAIL bp_drain%0d: got c=%b s=%h want c=0 s=%h", ne, co[0], s[0], 16'(16'h2001 + ne));
                end
                ne++;
            end
            if (vi[0] && iry[0]) idx++;
            tick();
        end
        n_chk++; if (ne !== 8) begin n_fail++; $display("FAIL bp_count: got %0d beats want 8", ne); end
    endtask

    task automatic test_reset_midflight();
        idle();
        for (int n = 0; n < 3; n++) begin
            vi[0] = 1'b1; va[0] = 16'(16'h0AA0 + n); vb[0] = 16'h0000; vcin[0] = 1'b0; vsub[0] = 1'b0;
            tick();
        end
        rst = 1'b1; va[0] = 16'h0BAD;
        tick();
        n_chk++; if (ov[0] !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got valid %b want 0", ov[0]); end
        rst = 1'b0; va[0] = 16'h1111; vb[0] = 16'h2222; vcin[0] = 1'b1;
        tick();
        vi[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_chk++;
            if (k == 4) begin
                if ({ov[0], co[0], s[0]} !== {1'b1, 1'b0, 16'h3334}) begin
                    n_fail++; $display("FAIL rst_after: got v=%b c=%b s=%h want v=1 c=0 s=3334", ov[0], co[0], s[0]);
                end
            end else if (ov[0] !== 1'b0) begin
                n_fail++; $display("FAIL rst_ghost k=%0d: got valid %b s=%h want 0", k, ov[0], s[0]);
            end
        end
    endtask

    task automatic test_random(input int d);
        logic [16:0] q[$];
        logic [16:0] e;
        logic        hold = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!hold) begin
                vi[d]   = (cyc < 260) && ($urandom_range(0, 3) != 0);
                va[d]   = 16'($urandom);
                vb[d]   = ($urandom_range(0, 7) == 0) ? va[d] : 16'($urandom);
                vcin[d] = 1'($urandom);
                vsub[d] = 1'($urandom);
            end
            ordy[d] = (cyc >= 260) || ($urandom_range(0, 3) != 0);
            #1;
            if (ov[d] && ordy[d]) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand%0d_extra: got s=%h with no beat outstanding", d, s[d]);
                end else begin
                    e = q.pop_front();
                    if ({co[d], s[d]} !== e) begin
                        n_fail++; $display("FAIL rand%0d: got c=%b s=%h want c=%b s=%h", d, co[d], s[d], e[16], e[15:0]);
                    end
                end
            end
            if (vi[d] && iry[d])
                q.push_back(vsub[d] ? {va[d] >= vb[d], 16'(va[d] - vb[d])}
                                    : 17'({1'b0, va[d]} + {1'b0, vb[d]} + 17'(vcin[d])));
            hold = vi[d] && !iry[d];
            tick();
        end
        vi[d] = 1'b0;
        n_chk++; if (q.size() != 0) begin n_fail++; $display("FAIL rand%0d_lost: got %0d beats missing want 0", d, q.size()); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            vi[d] = 1'b0; ordy[d] = 1'b1; va[d] = '0; vb[d] = '0; vcin[d] = 1'b0; vsub[d] = 1'b0;
        end
        test_reset();
        test_ripple();
        test_vectors();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        for (int d = 0; d < 3; d++) test_random(d);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
